fc_seq_ctrl: RTL

Sequencer for the fully-connected stage after pooling. On the pool/FC buffer's fc-start pulse it walks the 384-byte feature map as 48 words of 8 bytes each. For every output neuron it drives the feature-map read address and a weight-ROM address, and generates MAC enable, clear and last strobes aligned to read latency. It then hands each neuron's result downstream with a valid/ready handshake.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_strobe_pipe.sv | 34 +++
 rtl/fc_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected stage sequencer.
// Holds the FSM state encoding, the MAC strobe bundle and feature-map geometry.
package fc_pkg;

  localparam int unsigned FC_WORD_BYTES = 8;
  localparam int unsigned FC_NUM_WORDS  = 48;
  localparam int unsigned FC_FM_BYTES   = 384;
  localparam int unsigned FC_NUM_OUT    = 10;
  localparam int unsigned FC_FM_ADDR_W  = 16;
  localparam int unsigned FC_IDX_W      = 4;

  typedef enum logic [2:0] {
    FC_IDLE  = 3'd0,
    FC_RUN   = 3'd1,
    FC_DRAIN = 3'd2,
    FC_EMIT  = 3'd3,
    FC_DONE  = 3'd4
  } fc_state_t;

  // MAC control strobes travelling together down the read-latency pipe
  typedef struct packed {
    logic en;
    logic clr;
    logic last;
  } fc_strobe_t;

endpackage

// File: rtl/fc_strobe_pipe.sv
// Delays the {en, clr, last} MAC strobes by LAT cycles so they line up with
// data returning from the feature-map buffer and weight ROM.
// Ports: clk, rst (async, active-high), flush (sync clear of all stages),
//        d (strobes at address issue), q (strobes at MAC input).
module fc_strobe_pipe
  import fc_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  fc_strobe_t d,
  output fc_strobe_t q
);

  fc_strobe_t [LAT-1:0] sr;
  fc_strobe_t [LAT:0]   tap;

  // tap[0] is the input, tap[k] is the output of stage k-1
  assign tap = {sr, d};
  assign q   = tap[LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr <= tap[LAT-1:0];
    end
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Fully-connected stage sequencer. On i_fc_start it walks the feature map
// NUM_WORDS words per output neuron, drives feature-map and weight-ROM
// addresses, emits MAC strobes aligned to READ_LAT and hands each neuron
// result downstream over a valid/ready handshake.
// Ports: clk, rst (async, active-high), i_fc_start, i_abort,
//        o_fc_fm_addr / o_w_addr (read addresses),
//        o_mac_en / o_mac_clr / o_mac_last (MAC strobes),
//        o_res_valid / i_res_ready / o_res_idx (result handshake),
//        o_busy, o_done.
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = FC_NUM_WORDS,
  parameter int unsigned WORD_BYTES = FC_WORD_BYTES,
  parameter int unsigned NUM_OUT    = FC_NUM_OUT,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned WADDR_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_fc_start,
  input  logic                    i_abort,
  output logic [FC_FM_ADDR_W-1:0] o_fc_fm_addr,
  output logic [WADDR_W-1:0]      o_w_addr,
  output logic                    o_mac_en,
  output logic                    o_mac_clr,
  output logic                    o_mac_last,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [FC_IDX_W-1:0]     o_res_idx,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned WORD_W = $clog2(NUM_WORDS);
  localparam int unsigned DRN_W  = 2;

  fc_state_t                 state, state_n;
  logic [WORD_W-1:0]         word, word_n;
  logic [FC_IDX_W-1:0]       neuron, neuron_n;
  logic [WADDR_W-1:0]        w_base, w_base_n;
  logic [DRN_W-1:0]          drain_cnt, drain_cnt_n;
  logic [FC_FM_ADDR_W-1:0]   fm_addr_n;
  logic [WADDR_W-1:0]        w_addr_n;
  fc_strobe_t                strobe_c, strobe_q;
  logic                      flush_c;
  logic                      word_last_c;
  logic                      neuron_last_c;

  assign word_last_c   = (word == WORD_W'(NUM_WORDS - 1));
  assign neuron_last_c = (neuron == FC_IDX_W'(NUM_OUT - 1));

  // Next-state, counter and address computation. The address registers
  // are loaded on the edge into each RUN cycle so the visible address is
  // the one being issued in that cycle.
  always_comb begin
    state_n     = state;
    word_n      = word;
    neuron_n    = neuron;
    w_base_n    = w_base;
    drain_cnt_n = drain_cnt;
    fm_addr_n   = o_fc_fm_addr;
    w_addr_n    = o_w_addr;
    strobe_c    = '0;
    flush_c     = 1'b0;

    unique case (state)
      FC_IDLE: begin
        if (i_fc_start) begin
          state_n   = FC_RUN;
          word_n    = '0;
          neuron_n  = '0;
          w_base_n  = '0;
          fm_addr_n = '0;
          w_addr_n  = '0;
        end
      end
      FC_RUN: begin
        strobe_c.en   = 1'b1;
        strobe_c.clr  = (word == '0);
        strobe_c.last = word_last_c;
        if (word_last_c) begin
          state_n     = FC_DRAIN;
          drain_cnt_n = '0;
        end else begin
          word_n    = word + WORD_W'(1);
          fm_addr_n = o_fc_fm_addr + FC_FM_ADDR_W'(WORD_BYTES);
          w_addr_n  = o_w_addr + WADDR_W'(1);
        end
      end
      FC_DRAIN: begin
        // wait until the last issued strobe has reached the MAC
        if (drain_cnt == DRN_W'(READ_LAT - 1)) begin
          state_n = FC_EMIT;
        end else begin
          drain_cnt_n = drain_cnt + DRN_W'(1);
        end
      end
      FC_EMIT: begin
        if (i_res_ready) begin
          if (neuron_last_c) begin
            state_n = FC_DONE;
          end else begin
            state_n   = FC_RUN;
            neuron_n  = neuron + FC_IDX_W'(1);
            word_n    = '0;
            w_base_n  = w_base + WADDR_W'(NUM_WORDS);
            fm_addr_n = '0;
            w_addr_n  = w_base + WADDR_W'(NUM_WORDS);
          end
        end
      end
      FC_DONE: begin
        state_n = FC_IDLE;
      end
      default: begin
        state_n = FC_IDLE;
      end
    endcase

    // abort overrides everything; addresses keep their last value
    if (i_abort && (state != FC_IDLE)) begin
      state_n     = FC_IDLE;
      word_n      = '0;
      neuron_n    = '0;
      w_base_n    = '0;
      drain_cnt_n = '0;
      fm_addr_n   = o_fc_fm_addr;
      w_addr_n    = o_w_addr;
      flush_c     = 1'b1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FC_IDLE;
      word         <= '0;
      neuron       <= '0;
      w_base       <= '0;
      drain_cnt    <= '0;
      o_fc_fm_addr <= '0;
      o_w_addr     <= '0;
      o_res_valid  <= 1'b0;
      o_res_idx    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= state_n;
      word         <= word_n;
      neuron       <= neuron_n;
      w_base       <= w_base_n;
      drain_cnt    <= drain_cnt_n;
      o_fc_fm_addr <= fm_addr_n;
      o_w_addr     <= w_addr_n;
      o_res_valid  <= (state_n == FC_EMIT);
      o_res_idx    <= neuron_n;
      o_busy       <= (state_n != FC_IDLE);
      o_done       <= (state_n == FC_DONE);
    end
  end

  fc_strobe_pipe #(
    .LAT (READ_LAT)
  ) u_strobe_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .d     (strobe_c),
    .q     (strobe_q)
  );

  assign o_mac_en   = strobe_q.en;
  assign o_mac_clr  = strobe_q.clr;
  assign o_mac_last = strobe_q.last;

endmodule
